// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial 1011 pattern detector: state encodings
// and the pattern constant itself.
package seq_det_pkg;

  // Each state names the longest prefix of the pattern seen so far.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_1011 = 3'd4
  } state_t;

  // Pattern, MSB received first.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear first, then a saturating increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_1011.sv
// Serial detector for the bit pattern 1011 (first bit received first).
// Emits a registered one-cycle match pulse and keeps a saturating count of
// matches. OVERLAP selects whether the tail of a match may start the next.
//
// Input qualifier: din is consumed only on a rising edge where din_valid is
// high; there is no backpressure, so every valid bit is taken on that edge.
// With din_valid low the FSM holds and din is ignored entirely.
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       state_out
);

  state_t state_q;
  state_t state_d;
  logic   match_q;
  logic   hit_d;

  // Next-state and match-completion logic; unused encodings fall back to idle
  // on the next edge whether or not a valid bit is present.
  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    case (state_q)
      S_IDLE: if (din_valid) state_d = din ? S_1 : S_IDLE;
      S_1:    if (din_valid) state_d = din ? S_1 : S_10;
      S_10:   if (din_valid) state_d = din ? S_101 : S_IDLE;
      S_101: begin
        if (din_valid) begin
          state_d = din ? S_1011 : S_10;
          hit_d   = (din == PATTERN[0]);
        end
      end
      S_1011: begin
        if (din_valid) begin
          if (din) begin
            state_d = S_1;
          end else begin
            state_d = (OVERLAP != 0) ? S_10 : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and match pulse registers; the pulse is a single cycle because
  // hit_d needs a fresh valid bit taking S_101 to S_1011.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= hit_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_d),
    .clr   (clr_count),
    .count (match_count)
  );

  assign match     = match_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_seq_detector_1011.sv
// Bench for seq_detector_1011: one overlapping and one non-overlapping
// instance driven by the same inputs, checked every cycle against a
// sliding-window reference model through an expected-value queue.
module tb_seq_detector_1011;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       clr_count;
  logic       match_ov;
  logic       match_no;
  logic [7:0] count_ov;
  logic [7:0] count_no;
  logic [2:0] state_ov;
  logic [2:0] state_no;

  int n_checks;
  int n_pass;
  int pulses_ov;
  int pulses_no;

  // Expected entries: {match, count}; two per cycle, overlap instance first.
  logic [8:0] exp_q[$];

  // Reference model: last valid bits seen; the non-overlap window is wiped
  // after each match so a completed pattern cannot donate bits.
  logic [3:0]  h_ov, h_no;
  int unsigned c_ov, c_no;
  logic        m_ov, m_no;

  seq_detector_1011 #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .clr_count   (clr_count),
    .match       (match_ov),
    .match_count (count_ov),
    .state_out   (state_ov)
  );

  seq_detector_1011 #(.OVERLAP(0), .CNT_W(8)) dut_no (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .clr_count   (clr_count),
    .match       (match_no),
    .match_count (count_no),
    .state_out   (state_no)
  );

  // Clock and initial input values.
  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    clr_count = 1'b0;
  end
  always #5 clk = ~clk;

  // Drive one cycle, advance the model, then compare both instances.
  task automatic step(input logic b, input logic v, input logic c, input logic r);
    logic [8:0] e;
    logic [8:0] got;
    din = b; din_valid = v; clr_count = c; rst_n = r;
    @(posedge clk);
    if (!r) begin
      h_ov = 4'b0; h_no = 4'b0; c_ov = 0; c_no = 0; m_ov = 1'b0; m_no = 1'b0;
    end else begin
      m_ov = 1'b0;
      m_no = 1'b0;
      if (v) begin
        h_ov = {h_ov[2:0], b};
        h_no = {h_no[2:0], b};
        m_ov = (h_ov == 4'b1011);
        m_no = (h_no == 4'b1011);
        if (m_no) h_no = 4'b0;
      end
      if (c) c_ov = 0; else if (m_ov && c_ov < 255) c_ov = c_ov + 1;
      if (c) c_no = 0; else if (m_no && c_no < 255) c_no = c_no + 1;
    end
    exp_q.push_back({m_ov, c_ov[7:0]});
    exp_q.push_back({m_no, c_no[7:0]});
    #1;
    if (match_ov === 1'b1) pulses_ov++;
    if (match_no === 1'b1) pulses_no++;
    e = exp_q.pop_front();
    got = {match_ov, count_ov};
    n_checks++;
    if (got !== e) $display("FAIL sb_overlap t=%0t got match=%b cnt=%0d exp match=%b cnt=%0d",
                            $time, got[8], got[7:0], e[8], e[7:0]);
    else n_pass++;
    e = exp_q.pop_front();
    got = {match_no, count_no};
    n_checks++;
    if (got !== e) $display("FAIL sb_nooverlap t=%0t got match=%b cnt=%0d exp match=%b cnt=%0d",
                            $time, got[8], got[7:0], e[8], e[7:0]);
    else n_pass++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pulses_ov = 0;
    pulses_no = 0;
  endtask

  task automatic send_bits(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (state_ov !== 3'd0 || state_no !== 3'd0)
      $display("FAIL reset_state got %0d/%0d exp 0/0", state_ov, state_no);
    else n_pass++;
    pulses_ov = 0;
    pulses_no = 0;
  endtask

  task automatic test_stream();
    logic [6:0] s;
    s = 7'b1011011;
    do_reset();
    for (int i = 6; i >= 0; i--) step(s[i], 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (pulses_ov != 2 || count_ov !== 8'd2)
      $display("FAIL stream_overlap got pulses=%0d cnt=%0d exp 2/2", pulses_ov, count_ov);
    else n_pass++;
    n_checks++;
    if (pulses_no != 1 || count_no !== 8'd1 || state_no !== 3'd1)
      $display("FAIL stream_nooverlap got pulses=%0d cnt=%0d state=%0d exp 1/1/1",
               pulses_no, count_no, state_no);
    else n_pass++;
  endtask

  task automatic test_gapped();
    logic [3:0] s;
    s = 4'b1011;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      step(s[i], 1'b1, 1'b0, 1'b1);
      if (i != 0)
        for (int g = 0; g < 3; g++) step(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b1);
    end
    for (int g = 0; g < 4; g++) step(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (pulses_ov != 1 || count_ov !== 8'd1 || state_ov !== 3'd4)
      $display("FAIL gapped got pulses=%0d cnt=%0d state=%0d exp 1/1/4",
               pulses_ov, count_ov, state_ov);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (state_ov !== 3'd1 || state_no !== 3'd1 || pulses_ov != 0 || count_ov !== 8'd0)
      $display("FAIL reset_mid got state=%0d/%0d pulses=%0d cnt=%0d exp 1/1/0/0",
               state_ov, state_no, pulses_ov, count_ov);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 260; k++) send_bits(4'b1011);
    n_checks++;
    if (pulses_ov != 260 || count_ov !== 8'd255)
      $display("FAIL saturation_ov got pulses=%0d cnt=%0d exp 260/255", pulses_ov, count_ov);
    else n_pass++;
    n_checks++;
    if (pulses_no != 260 || count_no !== 8'd255)
      $display("FAIL saturation_no got pulses=%0d cnt=%0d exp 260/255", pulses_no, count_no);
    else n_pass++;
  endtask

  task automatic test_clr_collision();
    do_reset();
    for (int k = 0; k < 5; k++) send_bits(4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (count_ov !== 8'd5)
      $display("FAIL clr_precount got %0d exp 5", count_ov);
    else n_pass++;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (match_ov !== 1'b1 || count_ov !== 8'd0 || state_ov !== 3'd4)
      $display("FAIL clr_collision got match=%b cnt=%0d state=%0d exp 1/0/4",
               match_ov, count_ov, state_ov);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0),
           ($urandom_range(40, 0) == 0), 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream();
    test_gapped();
    test_reset_mid();
    test_saturation();
    test_clr_collision();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain got %0d entries exp 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
